// File: rtl/pipelined_delay_memory_if.sv
// Bus bundle for pipelined_delay_memory: write port, read request port and
// the valid-tagged read return. The master drives requests, the slave (the
// memory) drives the read return and status.
interface pipelined_delay_memory_if #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 8,
    parameter int READ_DELAY = 3
);
    localparam int CNT_W = $clog2(READ_DELAY + 1);

    logic              i_wr_en;
    logic [ADDR_W-1:0] i_write_addr;
    logic [DATA_W-1:0] i_data;
    logic              i_rd_en;
    logic [ADDR_W-1:0] i_read_addr;
    logic              o_data_ready;
    logic [DATA_W-1:0] o_data;
    logic [CNT_W-1:0]  o_rd_pending;
    logic              o_parity_err;

    modport master (
        output i_wr_en, i_write_addr, i_data, i_rd_en, i_read_addr,
        input  o_data_ready, o_data, o_rd_pending, o_parity_err
    );

    modport slave (
        input  i_wr_en, i_write_addr, i_data, i_rd_en, i_read_addr,
        output o_data_ready, o_data, o_rd_pending, o_parity_err
    );
endinterface

// File: rtl/pipelined_delay_memory.sv
// Simple-dual-port RAM with a fixed-latency, valid-tagged read return.
// A read accepted at edge k is presented for one cycle after edge
// k+READ_DELAY-1; reads are read-first against a same-edge write.
// Optional build macro DELAY_MEM_PARITY_EN stores an even-parity bit with
// each word and flags a mismatch on the presented word.
module pipelined_delay_memory #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 8,
    parameter int READ_DELAY = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    pipelined_delay_memory_if.slave  bus
);
    localparam int CNT_W = $clog2(READ_DELAY + 1);
    localparam int DEPTH = 2 ** ADDR_W;
`ifdef DELAY_MEM_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int MEM_W = DATA_W + PAR_W;

    logic [MEM_W-1:0]      r_mem   [DEPTH];
    logic [READ_DELAY-1:0] r_valid;
    logic [MEM_W-1:0]      r_word  [READ_DELAY];
    logic [CNT_W-1:0]      r_pend;

    logic [MEM_W-1:0]      w_wr_word;
    logic                  w_pend_dec;
    logic [DATA_W-1:0]     w_data_out;
    logic                  w_parity_err;

`ifdef DELAY_MEM_PARITY_EN
    assign w_wr_word = {^bus.i_data, bus.i_data};
`else
    assign w_wr_word = bus.i_data;
`endif

    // Storage write; requests are ignored while reset is held.
    // NOTE: the array has no reset - clearing every word would stop it mapping onto RAM.
    always_ff @(posedge clk) begin
        if (bus.i_wr_en && !rst) begin
            r_mem[bus.i_write_addr] <= w_wr_word;
        end
    end

    // Valid tags: stage 0 takes the read request, later stages shift along.
    // NOTE: non-blocking assignments let every stage see its predecessor's old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            r_valid[0] <= bus.i_rd_en;
            for (int n = 1; n < READ_DELAY; n++) begin
                r_valid[n] <= r_valid[n-1];
            end
        end
    end

    // Data path: samples the old array contents (read-first) and shifts them
    // alongside the valid tags; left unreset because the output is gated by valid.
    always_ff @(posedge clk) begin
        r_word[0] <= r_mem[bus.i_read_addr];
        for (int n = 1; n < READ_DELAY; n++) begin
            r_word[n] <= r_word[n-1];
        end
    end

    // A valid word enters the last stage on the edge that retires it from the count.
    generate
        if (READ_DELAY == 1) begin : g_dec_direct
            assign w_pend_dec = bus.i_rd_en;
        end else begin : g_dec_stage
            assign w_pend_dec = r_valid[READ_DELAY-2];
        end
    endgenerate

    // In-flight read counter: up on accept, down on arrival at the last stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            case ({bus.i_rd_en, w_pend_dec})
                2'b10:   r_pend <= r_pend + CNT_W'(1);
                2'b01:   r_pend <= r_pend - CNT_W'(1);
                default: r_pend <= r_pend;
            endcase
        end
    end

    // Output gating: data and parity flag are zero unless the last stage is valid.
    // NOTE: defaults first so no path through the block leaves an output unassigned.
    always_comb begin
        w_data_out   = '0;
        w_parity_err = 1'b0;
        if (r_valid[READ_DELAY-1]) begin
            w_data_out = r_word[READ_DELAY-1][DATA_W-1:0];
`ifdef DELAY_MEM_PARITY_EN
            w_parity_err = (^w_data_out) != r_word[READ_DELAY-1][DATA_W];
`endif
        end
    end

    assign bus.o_data_ready = r_valid[READ_DELAY-1];
    assign bus.o_data       = w_data_out;
    assign bus.o_rd_pending = r_pend;
    assign bus.o_parity_err = w_parity_err;
endmodule

// File: tb/tb_pipelined_delay_memory.sv
// Scoreboard bench for pipelined_delay_memory: directed scenarios plus a
// randomized phase. Each accepted read pushes its expected word and due edge
// into a queue; a negedge monitor pops and compares when the due edge arrives.
module tb_pipelined_delay_memory;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 8;
    localparam int READ_DELAY = 3;
    localparam int DEPTH      = 2 ** ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipelined_delay_memory_if #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_DELAY(READ_DELAY)
    ) bus ();

    pipelined_delay_memory #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_DELAY(READ_DELAY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
        logic              perr;
    } exp_t;

    exp_t              sb[$];
    logic [DATA_W-1:0] ref_mem [DEPTH];
    bit                ref_bad [DEPTH];
    int                written[$];
    int                edge_cnt = 0;
    int                n_checks = 0;
    int                n_errs   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Reference model: a read returns the word stored before this edge's write
    // and is due READ_DELAY-1 edges after acceptance; reset drops everything.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sb.delete();
        end else begin
            edge_cnt++;
            if (bus.i_rd_en) begin
                sb.push_back(exp_t'{due:  edge_cnt + READ_DELAY - 1,
                                    data: ref_mem[bus.i_read_addr],
                                    perr: ref_bad[bus.i_read_addr]});
            end
            if (bus.i_wr_en) begin
                ref_mem[bus.i_write_addr] = bus.i_data;
                ref_bad[bus.i_write_addr] = 1'b0;
            end
        end
    end

    // Monitor: compares outputs every cycle, mid-way between edges.
    always @(negedge clk) begin
        int   pend;
        exp_t e;
        if (rst) begin
            check("rst_ready",   {63'b0, bus.o_data_ready}, 64'd0);
            check("rst_data",    64'(bus.o_data), 64'd0);
            check("rst_pending", 64'(bus.o_rd_pending), 64'd0);
            check("rst_perr",    {63'b0, bus.o_parity_err}, 64'd0);
        end else begin
            pend = 0;
            foreach (sb[i]) if (sb[i].due > edge_cnt) pend++;
            check("rd_pending", 64'(bus.o_rd_pending), 64'(pend));
            if (sb.size() > 0 && sb[0].due == edge_cnt) begin
                e = sb.pop_front();
                check("ready",  {63'b0, bus.o_data_ready}, 64'd1);
                check("data",   64'(bus.o_data), 64'(e.data));
                check("perr",   {63'b0, bus.o_parity_err}, {63'b0, e.perr});
            end else begin
                check("idle_ready", {63'b0, bus.o_data_ready}, 64'd0);
                check("idle_data",  64'(bus.o_data), 64'd0);
                check("idle_perr",  {63'b0, bus.o_parity_err}, 64'd0);
            end
        end
    end

    task automatic drive(input bit wr, input int wa, input logic [DATA_W-1:0] wd,
                         input bit rd, input int ra);
        bus.i_wr_en      = wr;
        bus.i_write_addr = ADDR_W'(wa);
        bus.i_data       = wd;
        bus.i_rd_en      = rd;
        bus.i_read_addr  = ADDR_W'(ra);
        if (wr && !rst) written.push_back(wa);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, '0, 1'b0, 0);
    endtask

    initial begin
        int budget;
        bus.i_wr_en      = 1'b0;
        bus.i_write_addr = '0;
        bus.i_data       = '0;
        bus.i_rd_en      = 1'b0;
        bus.i_read_addr  = '0;
        foreach (ref_bad[i]) ref_bad[i] = 1'b0;

        // Reset then idle.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(10);

        // Basic latency.
        drive(1'b1, 'h10, 32'hDEADBEEF, 1'b0, 0);
        drive(1'b0, 0, '0, 1'b1, 'h10);
        idle(4);

        // Streaming: back-to-back reads.
        for (int i = 0; i < 8; i++) drive(1'b1, i, DATA_W'(i * 3), 1'b0, 0);
        for (int i = 0; i < 8; i++) drive(1'b0, 0, '0, 1'b1, i);
        idle(4);

        // Read/write collision on the same address.
        drive(1'b1, 5, 32'h1111, 1'b0, 0);
        drive(1'b1, 5, 32'h2222, 1'b1, 5);
        drive(1'b0, 0, '0, 1'b1, 5);
        idle(4);

        // Reset mid-flight: third read and a write arrive while reset is held.
        drive(1'b0, 0, '0, 1'b1, 'h10);
        drive(1'b0, 0, '0, 1'b1, 5);
        bus.i_rd_en      = 1'b1;
        bus.i_read_addr  = ADDR_W'(3);
        bus.i_wr_en      = 1'b1;
        bus.i_write_addr = ADDR_W'(5);
        bus.i_data       = 32'hBAD0BAD0;
        #1 rst = 1'b1;
        #1;
        check("async_rst_pending", 64'(bus.o_rd_pending), 64'd0);
        check("async_rst_ready",   {63'b0, bus.o_data_ready}, 64'd0);
        check("async_rst_data",    64'(bus.o_data), 64'd0);
        @(posedge clk);
        #1;
        idle(2);
        rst = 1'b0;
        idle(6);
        drive(1'b0, 0, '0, 1'b1, 5);
        idle(4);

`ifdef DELAY_MEM_PARITY_EN
        // Parity: corrupt one stored bit behind the design's back.
        drive(1'b1, 1, 32'h0000000F, 1'b0, 0);
        drive(1'b1, 2, 32'h00000007, 1'b0, 0);
        dut.r_mem[1][0] = ~dut.r_mem[1][0];
        ref_mem[1] = 32'h0000000E;
        ref_bad[1] = 1'b1;
        drive(1'b0, 0, '0, 1'b1, 1);
        drive(1'b0, 0, '0, 1'b1, 2);
        idle(4);
        drive(1'b1, 1, 32'h0000000F, 1'b0, 0);
`endif

        // Randomized traffic; reads only target addresses already written.
        for (int c = 0; c < 300; c++) begin
            bit wr;
            bit rd;
            int ra;
            wr = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 3) != 0);
            ra = written[$urandom_range(0, written.size() - 1)];
            drive(wr, int'($urandom_range(0, DEPTH - 1)), DATA_W'($urandom), rd, ra);
        end
        idle(1);

        // Drain the scoreboard within a bounded number of cycles.
        budget = 0;
        while (sb.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        if (sb.size() > 0) check("drain", 64'(sb.size()), 64'd0);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
